// File: rtl/reaction_ctrl.sv
// Reaction-time tester sequencer: arms on start, waits a fixed cue delay, then
// counts milliseconds in BCD until stop; tracks best time, fouls and saturation.
module reaction_ctrl #(
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned DELAY_MS = 1000
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  output logic        led,
  output logic [15:0] count_bcd,
  output logic [15:0] best_bcd,
  output logic        busy,
  output logic        foul,
  output logic        overflow
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = $clog2(DELAY_MS + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DLY_LAST  = DW'(DELAY_MS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_COUNT = 3'd2,
    S_HOLD  = 3'd3,
    S_FOUL  = 3'd4
  } state_t;

  state_t          state;
  logic            start_q;
  logic            stop_q;
  logic [PW-1:0]   presc;
  logic [DW-1:0]   dly_cnt;

  logic            start_rise;
  logic            stop_rise;
  logic            tick;
  logic            at_max;
  logic            carry;
  logic [15:0]     bcd_inc;

  // Edge detect, ms tick and BCD ripple increment
  always_comb begin
    start_rise = start & ~start_q;
    stop_rise  = stop & ~stop_q;
    tick       = (presc == PRESC_MAX);
    at_max     = (count_bcd == 16'h9999);
    bcd_inc    = count_bcd;
    carry      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (count_bcd[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  // Trial sequencer; led/busy/foul are updated alongside every state change
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      presc     <= '0;
      dly_cnt   <= '0;
      count_bcd <= 16'h0000;
      best_bcd  <= 16'h9999;
      overflow  <= 1'b0;
      led       <= 1'b0;
      busy      <= 1'b0;
      foul      <= 1'b0;
    end else begin
      start_q <= start;
      stop_q  <= stop;
      presc   <= tick ? '0 : presc + PW'(1);

      if (start_rise) begin
        // Start always (re)arms, even mid-trial, and beats a coincident stop
        state     <= S_DELAY;
        count_bcd <= 16'h0000;
        dly_cnt   <= '0;
        overflow  <= 1'b0;
        presc     <= '0;
        led       <= 1'b0;
        busy      <= 1'b1;
        foul      <= 1'b0;
      end else begin
        case (state)
          S_DELAY: begin
            if (stop_rise) begin
              state <= S_FOUL;
              busy  <= 1'b0;
              foul  <= 1'b1;
            end else if (tick) begin
              dly_cnt <= dly_cnt + DW'(1);
              if (dly_cnt == DLY_LAST) begin
                state <= S_COUNT;
                presc <= '0;
                led   <= 1'b1;
              end
            end
          end
          S_COUNT: begin
            // Stop wins over a same-cycle tick so the shown value is whole ms
            if (stop_rise) begin
              state <= S_HOLD;
              led   <= 1'b0;
              busy  <= 1'b0;
              if (count_bcd < best_bcd) best_bcd <= count_bcd;
            end else if (tick) begin
              if (at_max) begin
                overflow <= 1'b1;
                state    <= S_HOLD;
                led      <= 1'b0;
                busy     <= 1'b0;
              end else begin
                count_bcd <= bcd_inc;
              end
            end
          end
          S_FOUL: begin
            count_bcd <= 16'h0000;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reaction_ctrl.sv
// Self-checking bench for reaction_ctrl: directed scenarios plus random button
// traffic, compared each checked cycle against an integer-ms reference model.
module tb_reaction_ctrl;

  localparam int TD = 4;
  localparam int DM = 3;

  localparam int M_IDLE  = 0;
  localparam int M_DELAY = 1;
  localparam int M_COUNT = 2;
  localparam int M_HOLD  = 3;
  localparam int M_FOUL  = 4;

  logic        sysclk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        led;
  logic [15:0] count_bcd;
  logic [15:0] best_bcd;
  logic        busy;
  logic        foul;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  // Reference model: elapsed time kept as a plain integer number of ms
  int m_st, m_presc, m_dly, m_ms, m_best;
  bit m_ovf, m_sq, m_pq;

  reaction_ctrl #(.TICK_DIV(TD), .DELAY_MS(DM)) dut (
    .sysclk   (sysclk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .led      (led),
    .count_bcd(count_bcd),
    .best_bcd (best_bcd),
    .busy     (busy),
    .foul     (foul),
    .overflow (overflow)
  );

  always #5 sysclk = ~sysclk;

  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_presc = 0; m_dly = 0; m_ms = 0; m_best = 9999;
    m_ovf = 1'b0; m_sq = 1'b0; m_pq = 1'b0;
  endtask

  task automatic model_step(bit s, bit p);
    bit sr, pr, tk;
    sr = s && !m_sq;
    pr = p && !m_pq;
    tk = (m_presc == TD - 1);
    m_sq = s;
    m_pq = p;
    m_presc = tk ? 0 : m_presc + 1;
    if (sr) begin
      m_st = M_DELAY; m_ms = 0; m_dly = 0; m_ovf = 1'b0; m_presc = 0;
    end else begin
      case (m_st)
        M_DELAY: begin
          if (pr) m_st = M_FOUL;
          else if (tk) begin
            m_dly++;
            if (m_dly == DM) begin
              m_st = M_COUNT;
              m_presc = 0;
            end
          end
        end
        M_COUNT: begin
          if (pr) begin
            m_st = M_HOLD;
            if (m_ms < m_best) m_best = m_ms;
          end else if (tk) begin
            if (m_ms == 9999) begin
              m_ovf = 1'b1;
              m_st = M_HOLD;
            end else begin
              m_ms++;
            end
          end
        end
        default: begin
        end
      endcase
    end
  endtask

  task automatic cmp(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    cmp({tag, ".led"},      16'(led),      16'(m_st == M_COUNT));
    cmp({tag, ".count"},    count_bcd,     to_bcd(m_ms));
    cmp({tag, ".best"},     best_bcd,      to_bcd(m_best));
    cmp({tag, ".busy"},     16'(busy),     16'(m_st == M_DELAY || m_st == M_COUNT));
    cmp({tag, ".foul"},     16'(foul),     16'(m_st == M_FOUL));
    cmp({tag, ".overflow"}, 16'(overflow), 16'(m_ovf));
  endtask

  task automatic step(bit s, bit p, bit chk, string tag);
    start = s;
    stop  = p;
    @(posedge sysclk);
    model_step(s, p);
    #1;
    if (chk) check_all(tag);
  endtask

  task automatic async_reset(string tag);
    start = 1'b0;
    stop  = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(negedge sysclk);
    rst_n = 1'b1;
  endtask

  // Steps until the DUT lights the cue; returns cycles waited
  task automatic wait_led(bit s, string tag, output int n);
    n = 0;
    while (led !== 1'b1 && n < 200) begin
      step(s, 1'b0, 1'b1, tag);
      n++;
    end
    cmp({tag, ".led_seen"}, 16'(led), 16'd1);
  endtask

  task automatic wait_ms(bit s, int target, string tag);
    int n;
    n = 0;
    while (m_st == M_COUNT && m_ms < target && n < 50000) begin
      step(s, 1'b0, 1'b1, tag);
      n++;
    end
  endtask

  task automatic trial(int ms, string tag);
    int n;
    step(1'b1, 1'b0, 1'b1, tag);
    step(1'b0, 1'b0, 1'b1, tag);
    wait_led(1'b0, tag, n);
    wait_ms(1'b0, ms, tag);
    step(1'b0, 1'b1, 1'b1, tag);
    cmp({tag, ".held"}, count_bcd, to_bcd(ms));
    step(1'b0, 1'b0, 1'b1, tag);
  endtask

  initial begin
    int n;
    int prev;
    bit s_r, p_r;

    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    cmp("reset.best_const", best_bcd, 16'h9999);
    @(negedge sysclk);
    rst_n = 1'b1;
    repeat (9) step(1'b0, 1'b0, 1'b1, "idle");

    // Normal trial: 12 cycles to cue, stop 20 cycles later reads 0005
    step(1'b1, 1'b0, 1'b1, "normal.start");
    cmp("normal.busy", 16'(busy), 16'd1);
    wait_led(1'b0, "normal.delay", n);
    cmp("normal.cue_latency", 16'(n), 16'd12);
    repeat (20) step(1'b0, 1'b0, 1'b1, "normal.count");
    step(1'b0, 1'b1, 1'b1, "normal.stop");
    cmp("normal.count_const", count_bcd, 16'h0005);
    cmp("normal.led_off", 16'(led), 16'd0);
    cmp("normal.best_const", best_bcd, 16'h0005);
    step(1'b0, 1'b0, 1'b1, "normal.release");

    // Foul, stray stop, then recovery via start
    step(1'b1, 1'b0, 1'b1, "foul.start");
    repeat (5) step(1'b0, 1'b0, 1'b1, "foul.delay");
    step(1'b0, 1'b1, 1'b1, "foul.stop");
    cmp("foul.flag", 16'(foul), 16'd1);
    cmp("foul.count", count_bcd, 16'h0000);
    cmp("foul.best", best_bcd, 16'h0005);
    step(1'b0, 1'b0, 1'b1, "foul.gap");
    step(1'b0, 1'b1, 1'b1, "foul.stray");
    cmp("foul.stray_flag", 16'(foul), 16'd1);
    step(1'b0, 1'b0, 1'b1, "foul.gap2");
    step(1'b1, 1'b0, 1'b1, "foul.restart");
    cmp("foul.restart_foul", 16'(foul), 16'd0);
    cmp("foul.restart_busy", 16'(busy), 16'd1);
    step(1'b0, 1'b0, 1'b1, "foul.release");

    // Best tracking from a fresh reset
    async_reset("best.reset");
    trial(7, "best7");
    cmp("best.after7", best_bcd, 16'h0007);
    trial(3, "best3");
    cmp("best.after3", best_bcd, 16'h0003);
    trial(9, "best9");
    cmp("best.after9", best_bcd, 16'h0003);

    // Async reset mid-COUNT, no clock edge needed
    step(1'b1, 1'b0, 1'b1, "rst.start");
    wait_led(1'b0, "rst.delay", n);
    wait_ms(1'b0, 2, "rst.count");
    async_reset("rst.mid_count");
    cmp("rst.led", 16'(led), 16'd0);
    cmp("rst.best", best_bcd, 16'h9999);
    step(1'b0, 1'b0, 1'b1, "rst.after");
    cmp("rst.idle_busy", 16'(busy), 16'd0);

    // Stop coincident with tick: no increment
    step(1'b1, 1'b0, 1'b1, "stoptick.start");
    wait_led(1'b0, "stoptick.delay", n);
    wait_ms(1'b0, 2, "stoptick.count");
    n = 0;
    while (m_presc != TD - 1 && n < 10) begin
      step(1'b0, 1'b0, 1'b1, "stoptick.align");
      n++;
    end
    prev = m_ms;
    step(1'b0, 1'b1, 1'b1, "stoptick.stop");
    cmp("stoptick.no_inc", count_bcd, to_bcd(prev));
    step(1'b0, 1'b0, 1'b1, "stoptick.release");

    // Start held high through the whole trial does not retrigger in HOLD
    step(1'b1, 1'b0, 1'b1, "held.start");
    wait_led(1'b1, "held.delay", n);
    wait_ms(1'b1, 4, "held.count");
    step(1'b1, 1'b1, 1'b1, "held.stop");
    repeat (8) step(1'b1, 1'b0, 1'b1, "held.hold");
    cmp("held.busy", 16'(busy), 16'd0);
    cmp("held.count", count_bcd, 16'h0004);
    step(1'b0, 1'b0, 1'b1, "held.release");

    // Simultaneous start/stop in COUNT restarts
    step(1'b1, 1'b0, 1'b1, "both.start");
    step(1'b0, 1'b0, 1'b1, "both.low");
    wait_led(1'b0, "both.delay", n);
    wait_ms(1'b0, 2, "both.count");
    step(1'b1, 1'b1, 1'b1, "both.edge");
    cmp("both.busy", 16'(busy), 16'd1);
    cmp("both.led", 16'(led), 16'd0);
    cmp("both.count", count_bcd, 16'h0000);
    step(1'b0, 1'b0, 1'b1, "both.release");

    // Random button traffic
    for (int i = 0; i < 1500; i++) begin
      s_r = ($urandom_range(0, 39) == 0);
      p_r = ($urandom_range(0, 9) == 0);
      step(s_r, p_r, 1'b1, "random");
    end

    // Carry chain and saturation after a 6 ms best
    async_reset("sat.reset");
    trial(6, "sat.pre");
    step(1'b1, 1'b0, 1'b1, "sat.start");
    step(1'b0, 1'b0, 1'b1, "sat.low");
    wait_led(1'b0, "sat.delay", n);
    n = 0;
    prev = m_ms;
    while (m_st == M_COUNT && n < 50000) begin
      step(1'b0, 1'b0, 1'b0, "sat");
      n++;
      if (m_ms != prev && (m_ms == 9 || m_ms == 10 || m_ms == 99 || m_ms == 100 ||
                           m_ms == 999 || m_ms == 1000 || m_ms == 9999)) begin
        check_all("sat.carry");
      end
      if (m_ms == 1000 && prev == 999) cmp("sat.k_carry", count_bcd, 16'h1000);
      prev = m_ms;
    end
    check_all("sat.end");
    cmp("sat.overflow", 16'(overflow), 16'd1);
    cmp("sat.count", count_bcd, 16'h9999);
    cmp("sat.busy", 16'(busy), 16'd0);
    cmp("sat.best", best_bcd, 16'h0006);
    repeat (6) step(1'b0, 1'b1, 1'b1, "sat.hold");
    step(1'b1, 1'b0, 1'b1, "sat.restart");
    cmp("sat.ovf_cleared", 16'(overflow), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
